// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode encodings, FSM state type and opcode classification helpers
// for the ALU instruction sequencer.
package cpu_ctrl_pkg;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      S_LDY = 3'd1,
      S_EXE = 3'd2,
      S_WLO = 3'd3,
      S_WHI = 3'd4
   } state_t;

   // True for every opcode this sequencer knows how to run.
   function automatic logic is_legal(input logic [4:0] op);
      logic ok;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
         OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT: ok = 1'b1;
         default:                                       ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Unary ops take only ra, so the Y-load cycle is skipped.
   function automatic logic is_unary(input logic [4:0] op);
      return (op == OP_NEG) || (op == OP_NOT);
   endfunction

   // Ops producing a 64-bit result written to LO then HI.
   function automatic logic is_hilo(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Register-index to one-hot strobe decoder with enable.
module reg_sel_decoder #(
   parameter int NREG = 16,
   parameter int IDXW = 4
) (
   input  logic [IDXW-1:0] idx,
   input  logic            en,
   output logic [NREG-1:0] onehot
);

   // Raise exactly one bit when enabled, none otherwise.
   always_comb begin
      onehot = {NREG{1'b0}};
      if (en) begin
         onehot[idx] = 1'b1;
      end else begin
         onehot = {NREG{1'b0}};
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Moore FSM sequencing one register-to-register ALU instruction through the
// datapath. Outputs are registered: they are decoded from the next state and
// next latched fields, so each strobe appears in the same cycle the state
// register holds that state, free of glitches.
module alu_op_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int NREG = 16,
   parameter int IDXW = 4
) (
   input  logic            clock,
   input  logic            clear,
   input  logic            start,
   input  logic [4:0]      opcode,
   input  logic [IDXW-1:0] ra,
   input  logic [IDXW-1:0] rb,
   input  logic [IDXW-1:0] rc,
   input  logic            hold,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [4:0]      ops,
   output logic [NREG-1:0] reg_out,
   output logic [NREG-1:0] reg_in,
   output logic            RYout,
   output logic            RYin,
   output logic            RZin,
   output logic            RZLOout,
   output logic            RZHIout,
   output logic            HIin,
   output logic            LOin
);

   state_t          state_r, state_s;
   logic [4:0]      op_r, op_s;
   logic [IDXW-1:0] ra_r, ra_s, rb_r, rb_s, rc_r, rc_s;

   logic            err_s, busy_s, done_s;
   logic [4:0]      ops_s;
   logic            out_en_s, in_en_s;
   logic [IDXW-1:0] out_idx_s, in_idx_s;
   logic [NREG-1:0] reg_out_s, reg_in_s;
   logic            ryout_s, ryin_s, rzin_s, rzlo_s, rzhi_s, hiin_s, loin_s;

   // State register and latched instruction fields.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_r <= IDLE;
         op_r    <= 5'b00000;
         ra_r    <= {IDXW{1'b0}};
         rb_r    <= {IDXW{1'b0}};
         rc_r    <= {IDXW{1'b0}};
      end else begin
         state_r <= state_s;
         op_r    <= op_s;
         ra_r    <= ra_s;
         rb_r    <= rb_s;
         rc_r    <= rc_s;
      end
   end

   // Next-state logic: accept in IDLE, freeze on hold, else advance.
   always_comb begin
      state_s = state_r;
      op_s    = op_r;
      ra_s    = ra_r;
      rb_s    = rb_r;
      rc_s    = rc_r;
      err_s   = 1'b0;
      if (state_r == IDLE) begin
         if (start && is_legal(opcode)) begin
            op_s    = opcode;
            ra_s    = ra;
            rb_s    = rb;
            rc_s    = rc;
            state_s = is_unary(opcode) ? S_EXE : S_LDY;
         end else begin
            err_s   = start;
         end
      end else if (hold) begin
         state_s = state_r;
      end else begin
         case (state_r)
            S_LDY:   state_s = S_EXE;
            S_EXE:   state_s = S_WLO;
            S_WLO:   state_s = is_hilo(op_r) ? S_WHI : IDLE;
            S_WHI:   state_s = IDLE;
            default: state_s = IDLE;
         endcase
      end
   end

   // Strobe decode for the state about to be entered.
   always_comb begin
      busy_s    = (state_s != IDLE);
      done_s    = 1'b0;
      ops_s     = 5'b00000;
      out_en_s  = 1'b0;
      out_idx_s = {IDXW{1'b0}};
      in_en_s   = 1'b0;
      in_idx_s  = {IDXW{1'b0}};
      ryout_s   = 1'b0;
      ryin_s    = 1'b0;
      rzin_s    = 1'b0;
      rzlo_s    = 1'b0;
      rzhi_s    = 1'b0;
      hiin_s    = 1'b0;
      loin_s    = 1'b0;
      case (state_s)
         S_LDY: begin
            out_en_s  = 1'b1;
            out_idx_s = rb_s;
            ryin_s    = 1'b1;
         end
         S_EXE: begin
            out_en_s  = 1'b1;
            out_idx_s = ra_s;
            ryout_s   = 1'b1;
            rzin_s    = 1'b1;
            ops_s     = op_s;
         end
         S_WLO: begin
            rzlo_s = 1'b1;
            if (is_hilo(op_s)) begin
               loin_s   = 1'b1;
            end else begin
               in_en_s  = 1'b1;
               in_idx_s = rc_s;
               done_s   = 1'b1;
            end
         end
         S_WHI: begin
            rzhi_s = 1'b1;
            hiin_s = 1'b1;
            done_s = 1'b1;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   reg_sel_decoder #(.NREG(NREG), .IDXW(IDXW)) u_out_dec (
      .idx    (out_idx_s),
      .en     (out_en_s),
      .onehot (reg_out_s)
   );

   reg_sel_decoder #(.NREG(NREG), .IDXW(IDXW)) u_in_dec (
      .idx    (in_idx_s),
      .en     (in_en_s),
      .onehot (reg_in_s)
   );

   // Output register; async clear forces every strobe low at once.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         ops     <= 5'b00000;
         reg_out <= {NREG{1'b0}};
         reg_in  <= {NREG{1'b0}};
         RYout   <= 1'b0;
         RYin    <= 1'b0;
         RZin    <= 1'b0;
         RZLOout <= 1'b0;
         RZHIout <= 1'b0;
         HIin    <= 1'b0;
         LOin    <= 1'b0;
      end else begin
         busy    <= busy_s;
         done    <= done_s;
         err     <= err_s;
         ops     <= ops_s;
         reg_out <= reg_out_s;
         reg_in  <= reg_in_s;
         RYout   <= ryout_s;
         RYin    <= ryin_s;
         RZin    <= rzin_s;
         RZLOout <= rzlo_s;
         RZHIout <= rzhi_s;
         HIin    <= hiin_s;
         LOin    <= loin_s;
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: stimulus pushes hand-written
// per-cycle output snapshots, a negedge monitor pops and compares them.
module tb_alu_op_sequencer;
   import cpu_ctrl_pkg::*;

   typedef logic [46:0] vec_t;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic        start = 1'b0;
   logic        hold  = 1'b0;
   logic [4:0]  opcode = 5'b00000;
   logic [3:0]  ra = 4'd0, rb = 4'd0, rc = 4'd0;
   logic        busy, done, err;
   logic [4:0]  ops;
   logic [15:0] reg_out, reg_in;
   logic        RYout, RYin, RZin, RZLOout, RZHIout, HIin, LOin;

   vec_t act;
   vec_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;

   // st bits: {RYout,RYin,RZin,RZLOout,RZHIout,HIin,LOin}
   localparam logic [6:0] ST_LDY = 7'b0100000;
   localparam logic [6:0] ST_EXE = 7'b1010000;
   localparam logic [6:0] ST_WLO = 7'b0001000;
   localparam logic [6:0] ST_WLH = 7'b0001001;
   localparam logic [6:0] ST_WHI = 7'b0000110;

   alu_op_sequencer #(.NREG(16), .IDXW(4)) dut (
      .clock(clock), .clear(clear), .start(start), .opcode(opcode),
      .ra(ra), .rb(rb), .rc(rc), .hold(hold),
      .busy(busy), .done(done), .err(err), .ops(ops),
      .reg_out(reg_out), .reg_in(reg_in),
      .RYout(RYout), .RYin(RYin), .RZin(RZin), .RZLOout(RZLOout),
      .RZHIout(RZHIout), .HIin(HIin), .LOin(LOin)
   );

   always #5 clock = ~clock;

   assign act = {busy, done, err, ops, reg_out, reg_in,
                 RYout, RYin, RZin, RZLOout, RZHIout, HIin, LOin};

   function automatic vec_t mk(input logic bsy, input logic dn, input logic er,
                               input logic [4:0] o, input logic [15:0] ro,
                               input logic [15:0] ri, input logic [6:0] st);
      return {bsy, dn, er, o, ro, ri, st};
   endfunction

   // Monitor: compares each busy/err cycle against the scoreboard, and
   // checks that quiet IDLE cycles really drive nothing.
   initial begin
      vec_t exp_v;
      forever begin
         @(negedge clock);
         if (clear === 1'b1) begin
            if (busy === 1'b1 || err === 1'b1) begin
               compared++;
               if (sb.size() == 0) begin
                  mismatched++;
                  $display("FAIL unexpected_output: got %h, required no output", act);
               end else begin
                  exp_v = sb.pop_front();
                  if (act !== exp_v) begin
                     mismatched++;
                     $display("FAIL cycle_trace @%0t: got %h, required %h", $time, act, exp_v);
                  end
               end
            end else begin
               compared++;
               if (act !== 47'd0) begin
                  mismatched++;
                  $display("FAIL idle_quiet @%0t: got %h, required 0", $time, act);
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic issue(input logic [4:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] c);
      @(posedge clock); #1;
      start = 1'b1; opcode = op; ra = a; rb = b; rc = c;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while ((busy === 1'b1 || sb.size() != 0) && n < 60) begin
         @(posedge clock);
         n++;
      end
      compared++;
      if (n >= 60) begin
         mismatched++;
         $display("FAIL %s_timeout: busy=%0b pending=%0d, required idle with 0 pending",
                  name, busy, sb.size());
         sb.delete();
      end
      @(posedge clock); #1;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clock);
      #1;
      compared++;
      if (act !== 47'd0) begin
         mismatched++;
         $display("FAIL reset_state: got %h, required 0", act);
      end
      clear = 1'b1;

      // AND ra=2 rb=1 rc=1
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'b00000, 16'h0002, 16'h0000, ST_LDY));
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'b00101, 16'h0004, 16'h0000, ST_EXE));
      sb.push_back(mk(1'b1, 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h0002, ST_WLO));
      issue(OP_AND, 4'd2, 4'd1, 4'd1);
      wait_done("and");

      // MUL ra=3 rb=4 rc=5
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'b00000, 16'h0010, 16'h0000, ST_LDY));
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'b01111, 16'h0008, 16'h0000, ST_EXE));
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'b00000, 16'h0000, 16'h0000, ST_WLH));
      sb.push_back(mk(1'b1, 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h0000, ST_WHI));
      issue(OP_MUL, 4'd3, 4'd4, 4'd5);
      wait_done("mul");

      // NOT ra=6 rc=7 (rb ignored)
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'b10010, 16'h0040, 16'h0000, ST_EXE));
      sb.push_back(mk(1'b1, 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h0080, ST_WLO));
      issue(OP_NOT, 4'd6, 4'd9, 4'd7);
      wait_done("not");

      // Illegal opcode
      sb.push_back(mk(1'b0, 1'b0, 1'b1, 5'b00000, 16'h0000, 16'h0000, 7'b0000000));
      issue(5'b11111, 4'd1, 4'd2, 4'd3);
      wait_done("illegal");

      // ADD with a SUB start during LDY that must be ignored
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'b00000, 16'h0004, 16'h0000, ST_LDY));
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'b00011, 16'h0002, 16'h0000, ST_EXE));
      sb.push_back(mk(1'b1, 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h0008, ST_WLO));
      issue(OP_ADD, 4'd1, 4'd2, 4'd3);
      start = 1'b1; opcode = OP_SUB; ra = 4'd9; rb = 4'd10; rc = 4'd11;
      @(posedge clock); #1;
      start = 1'b0;
      wait_done("busy_ignore");

      // SUB with hold for 3 cycles in S_EXE
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'b00000, 16'h0020, 16'h0000, ST_LDY));
      repeat (4) sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'b00100, 16'h0010, 16'h0000, ST_EXE));
      sb.push_back(mk(1'b1, 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h0040, ST_WLO));
      issue(OP_SUB, 4'd4, 4'd5, 4'd6);
      @(posedge clock); #1;
      hold = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      hold = 1'b0;
      wait_done("hold_exe");

      // DIV with hold in S_WHI: done stays high for 3 cycles
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'b00000, 16'h0800, 16'h0000, ST_LDY));
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'b10000, 16'h0400, 16'h0000, ST_EXE));
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'b00000, 16'h0000, 16'h0000, ST_WLH));
      repeat (3) sb.push_back(mk(1'b1, 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h0000, ST_WHI));
      issue(OP_DIV, 4'd10, 4'd11, 4'd12);
      repeat (3) @(posedge clock);
      #1;
      hold = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      hold = 1'b0;
      wait_done("hold_whi");

      // NEG ra=0 rc=15 accepted while hold=1 in IDLE
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'b10001, 16'h0001, 16'h0000, ST_EXE));
      sb.push_back(mk(1'b1, 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h8000, ST_WLO));
      @(posedge clock); #1;
      hold = 1'b1; start = 1'b1; opcode = OP_NEG; ra = 4'd0; rb = 4'd3; rc = 4'd15;
      @(posedge clock); #1;
      hold = 1'b0; start = 1'b0;
      wait_done("hold_idle");

      // OR with ra==rb==rc
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'b00000, 16'h0020, 16'h0000, ST_LDY));
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'b00110, 16'h0020, 16'h0000, ST_EXE));
      sb.push_back(mk(1'b1, 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h0020, ST_WLO));
      issue(OP_OR, 4'd5, 4'd5, 4'd5);
      wait_done("same_regs");

      // Async clear in the middle of S_EXE
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'b00000, 16'h0004, 16'h0000, ST_LDY));
      issue(OP_ADD, 4'd1, 4'd2, 4'd3);
      @(posedge clock); #3;
      clear = 1'b0;
      #1;
      compared++;
      if (act !== 47'd0) begin
         mismatched++;
         $display("FAIL async_clear: got %h, required 0", act);
      end
      sb.delete();
      @(posedge clock); #1;
      clear = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("FAIL post_clear_busy: got %0b, required 0", busy);
      end

      // ADD after reset completes normally
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'b00000, 16'h0200, 16'h0000, ST_LDY));
      sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'b00011, 16'h0100, 16'h0000, ST_EXE));
      sb.push_back(mk(1'b1, 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h0400, ST_WLO));
      issue(OP_ADD, 4'd8, 4'd9, 4'd10);
      wait_done("post_clear_add");

      repeat (3) @(posedge clock);
      #1;
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Moore FSM that sequences the register datapath through one register-to-register ALU instruction.
- Accepts a decoded instruction (opcode plus ra/rb/rc register indices) via a start/busy/done handshake.
- Drives the datapath bus-out/bus-in strobes and the 5-bit ALU `ops` select, cycle by cycle.
- Sits between the future instruction decoder and the DataPath; it replaces hand-sequenced control strobes.

Parameters:
- NREG, 16, number of general registers; width of reg_out/reg_in one-hot vectors.
- IDXW, 4, register index width (log2 NREG).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- opcode  in  5  ALU operation code (package encodings).
- ra  in  IDXW  source A register index.
- rb  in  IDXW  source B register index (ignored for unary ops).
- rc  in  IDXW  destination register index.
- hold  in  1  freezes the FSM in its current state; strobes remain asserted.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse in the final write cycle.
- err  out  1  one-cycle pulse when start arrives with an illegal opcode.
- ops  out  5  ALU select to DataPath.
- reg_out  out  NREG  one-hot GPR bus-drive strobes.
- reg_in  out  NREG  one-hot GPR load strobes.
- RYout, RYin, RZin, RZLOout, RZHIout, HIin, LOin  out  1 each  datapath strobes.

Behaviour:
- Reset (clear=0, async): state=IDLE; latched fields cleared; all outputs 0, including ops=5'b00000.
- All outputs are decoded from the state register plus latched opcode/ra/rb/rc (Moore). No output depends combinationally on inputs.
- IDLE:
  - If start=1 and opcode is legal: latch opcode/ra/rb/rc. Next state is S_EXE for unary ops (NEG, NOT), otherwise S_LDY.
  - If start=1 and opcode is illegal: err pulses next cycle; stay IDLE; no strobes.
- S_LDY: reg_out[rb]=1, RYin=1.
- S_EXE: reg_out[ra]=1, RYout=1, RZin=1, ops=latched opcode.
- S_WLO:
  - RZLOout=1.
  - MUL/DIV: LOin=1; go to S_WHI.
  - All other ops: reg_in[rc]=1, done=1; go to IDLE.
- S_WHI (MUL/DIV only): RZHIout=1, HIin=1, done=1; go to IDLE.
- Latency, measured from the accept edge to the done cycle:
  - unary ops: 2 cycles.
  - binary ops: 3 cycles.
  - MUL/DIV: 4 cycles.
- busy=1 in every non-IDLE state. start is ignored while busy; it does not queue.
- done and the next accept: IDLE is entered the cycle after done, so back-to-back instructions take a minimum of 1 idle cycle between them.
- hold=1 in any non-IDLE state: state and all strobes are held unchanged. done stays high for as long as the hold lasts in a done state.
- hold in IDLE has no effect; start is still accepted.
- ra==rb or rc==ra is legal and gets no special handling.
- At most one bit of reg_out and one bit of reg_in is ever high.
- ops is 0 outside S_EXE.
- Reset mid-sequence aborts immediately. No write occurs after reset deassertion; the FSM restarts in IDLE.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - 5-bit opcode constants: ADD=00011, SUB=00100, AND=00101, OR=00110, SHR=00111, SHRA=01000, SHL=01001, ROR=01010, ROL=01011, MUL=01111, DIV=10000, NEG=10001, NOT=10010.
  - is_legal, is_unary and is_hilo helper functions.
  - State enum: IDLE, S_LDY, S_EXE, S_WLO, S_WHI.
- One sub-module: reg_sel_decoder (IDXW to NREG one-hot with enable), instantiated twice, once for reg_out and once for reg_in.

Test Plan:
- AND, ra=2, rb=1, rc=1, start for 1 cycle →
  - cycle+1: reg_out=0x0002, RYin=1.
  - cycle+2: reg_out=0x0004, RYout=RZin=1, ops=00101.
  - cycle+3: RZLOout=1, reg_in=0x0002, done=1.
  - cycle+4: busy=0.
- MUL, ra=3, rb=4, rc=5 →
  - S_WLO: LOin=1 and reg_in=0.
  - S_WHI: RZHIout=HIin=1, done=1.
  - Total 4 cycles busy.
- NOT, ra=6, rc=7 → no S_LDY cycle; S_EXE has reg_out=0x0040 and ops=10010; next cycle reg_in=0x0080, done=1.
- Illegal opcode 11111 with start → err=1 for one cycle; busy stays 0; all strobes stay 0. A second start with SUB during a running ADD is ignored (exactly one done).
- hold=1 for 3 cycles during S_EXE → RZin/ops held for 4 cycles total; done arrives 3 cycles late; no duplicate reg_in pulse.
- clear asserted asynchronously mid-S_EXE (between edges) → all outputs 0 immediately; after release, IDLE and busy=0; a new ADD completes normally.
